rpn_stack_master: RTL and testbench

//  Initiator for the 5-bit LIFO stack interface. Consumes a token stream and evaluates

---
 rtl/rpn_pkg.sv | 32 +++
 rtl/rpn_stack_master_if.sv | 34 +++
 rtl/rpn_alu.sv | 28 ++
 rtl/rpn_stack_master.sv | 171 +++++++++++++++++
 tb/tb_rpn_stack_master.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpn_pkg.sv
// rpn_pkg: shared constants for the RPN stack controller.
//   - default operand/stack sizing
//   - token-type and operator opcode encodings
//   - controller state encoding
package rpn_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_DEPTH = 10;

  localparam logic [1:0] TOK_OPERAND  = 2'b00;
  localparam logic [1:0] TOK_OPERATOR = 2'b01;
  localparam logic [1:0] TOK_EVAL     = 2'b10;
  localparam logic [1:0] TOK_RSVD     = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH_OP,
    S_POP_B,
    S_CAP_B,
    S_POP_A,
    S_CAP_A,
    S_PUSH_R,
    S_POP_R,
    S_CAP_R
  } state_t;

endpackage

// File: rtl/rpn_stack_master_if.sv
// rpn_stack_master_if: token stream handshake plus the LIFO stack access bus.
//   Tok_Valid/Tok_Ready/Tok_Type/Tok_Data : token source -> controller
//   St_Push/St_Pop/St_Din                 : controller -> stack
//   St_Dout/St_Full/St_Has_Data           : stack -> controller
// modport master: the controller's view; modport slave: the environment's view
// (token source and stack together).
interface rpn_stack_master_if
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             Tok_Valid;
  logic             Tok_Ready;
  logic [1:0]       Tok_Type;
  logic [WIDTH-1:0] Tok_Data;
  logic             St_Push;
  logic             St_Pop;
  logic [WIDTH-1:0] St_Din;
  logic [WIDTH-1:0] St_Dout;
  logic             St_Full;
  logic             St_Has_Data;

  modport master (
    input  Tok_Valid, Tok_Type, Tok_Data, St_Dout, St_Full, St_Has_Data,
    output Tok_Ready, St_Push, St_Pop, St_Din
  );

  modport slave (
    output Tok_Valid, Tok_Type, Tok_Data, St_Dout, St_Full, St_Has_Data,
    input  Tok_Ready, St_Push, St_Pop, St_Din
  );

endinterface

// File: rtl/rpn_alu.sv
// rpn_alu: combinational operator evaluation, modulo 2^WIDTH.
//   i_opcode : OP_ADD / OP_SUB / OP_AND / OP_XOR
//   i_op_a   : deeper operand (first pushed)
//   i_op_b   : top-of-stack operand
//   o_result : i_op_a <op> i_op_b, truncated to WIDTH (no carry/borrow out)
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       i_opcode,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_opcode)
      OP_ADD:  o_result = i_op_a + i_op_b;
      OP_SUB:  o_result = i_op_a - i_op_b;
      OP_AND:  o_result = i_op_a & i_op_b;
      OP_XOR:  o_result = i_op_a ^ i_op_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_master.sv
// rpn_stack_master: evaluates reverse-Polish token streams using an external LIFO.
//   clk, RstN     : clock, async active-low reset (shared with the stack)
//   bus (master)  : token handshake in, stack push/pop/data out, stack status in
//   Result        : last evaluated value, held until the next evaluate
//   Result_Valid  : one-cycle pulse when Result is updated
//   Err_Ovf       : sticky, operand pushed onto a full stack
//   Err_Unf       : sticky, operator/evaluate with too few entries
//
// state     | meaning
// ----------+------------------------------------------------
// S_IDLE    | waiting for a token; only state with Tok_Ready
// S_PUSH_OP | push the sampled operand
// S_POP_B   | pop top-of-stack (right operand)
// S_CAP_B   | stack output valid, capture operand B
// S_POP_A   | pop next entry (left operand)
// S_CAP_A   | capture operand A
// S_PUSH_R  | push A <op> B
// S_POP_R   | pop the final value for evaluate
// S_CAP_R   | capture Result, raise Result_Valid
module rpn_stack_master
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               RstN,
  rpn_stack_master_if.master bus,
  output logic [WIDTH-1:0]   Result,
  output logic               Result_Valid,
  output logic               Err_Ovf,
  output logic               Err_Unf
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_tok_ready;
  logic [DW-1:0]    r_depth;
  logic [WIDTH-1:0] r_tok_data;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_err_ovf;
  logic             r_err_unf;

  logic             w_hs;
  logic             w_ovf;
  logic             w_opr_unf;
  logic             w_eval_unf;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_din;
  logic [WIDTH-1:0] w_alu_result;

  // The internal depth counter decides; stack status flags only veto.
  assign w_hs       = bus.Tok_Valid & r_tok_ready;
  assign w_ovf      = (r_depth == DEPTH_MAX) | bus.St_Full;
  assign w_opr_unf  = (r_depth < DW'(2)) | ~bus.St_Has_Data;
  assign w_eval_unf = (r_depth == '0) | ~bus.St_Has_Data;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .i_opcode (r_tok_data[1:0]),
    .i_op_a   (r_op_a),
    .i_op_b   (r_op_b),
    .o_result (w_alu_result)
  );

  // Ready is registered from the next state so that it reads 0 during reset
  // and is high exactly in the IDLE cycles afterwards.
  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      r_state     <= S_IDLE;
      r_tok_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_tok_ready <= (w_next_state == S_IDLE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          case (bus.Tok_Type)
            TOK_OPERAND:  if (!w_ovf)      w_next_state = S_PUSH_OP;
            TOK_OPERATOR: if (!w_opr_unf)  w_next_state = S_POP_B;
            TOK_EVAL:     if (!w_eval_unf) w_next_state = S_POP_R;
            TOK_RSVD:     w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
          endcase
        end
      end
      S_PUSH_OP: w_next_state = S_IDLE;
      S_POP_B:   w_next_state = S_CAP_B;
      S_CAP_B:   w_next_state = S_POP_A;
      S_POP_A:   w_next_state = S_CAP_A;
      S_CAP_A:   w_next_state = S_PUSH_R;
      S_PUSH_R:  w_next_state = S_IDLE;
      S_POP_R:   w_next_state = S_CAP_R;
      S_CAP_R:   w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_din  = '0;
    case (r_state)
      S_PUSH_OP: begin
        w_push = 1'b1;
        w_din  = r_tok_data;
      end
      S_PUSH_R: begin
        w_push = 1'b1;
        w_din  = w_alu_result;
      end
      S_POP_B, S_POP_A, S_POP_R: w_pop = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      r_depth        <= '0;
      r_tok_data     <= '0;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      if (w_push)     r_depth <= r_depth + 1'b1;
      else if (w_pop) r_depth <= r_depth - 1'b1;
      if (w_hs) r_tok_data <= bus.Tok_Data;
      if (r_state == S_CAP_B) r_op_b <= bus.St_Dout;
      if (r_state == S_CAP_A) r_op_a <= bus.St_Dout;
      if (r_state == S_CAP_R) r_result <= bus.St_Dout;
      r_result_valid <= (r_state == S_CAP_R);
    end
  end

  // Rejected tokens are consumed with no stack access; flags stick until reset.
  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else if (w_hs) begin
      case (bus.Tok_Type)
        TOK_OPERAND:  if (w_ovf)      r_err_ovf <= 1'b1;
        TOK_OPERATOR: if (w_opr_unf)  r_err_unf <= 1'b1;
        TOK_EVAL:     if (w_eval_unf) r_err_unf <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.Tok_Ready = r_tok_ready;
  assign bus.St_Push   = w_push;
  assign bus.St_Pop    = w_pop;
  assign bus.St_Din    = w_din;
  assign Result        = r_result;
  assign Result_Valid  = r_result_valid;
  assign Err_Ovf       = r_err_ovf;
  assign Err_Unf       = r_err_unf;

endmodule

// File: tb/tb_rpn_stack_master.sv
// tb_rpn_stack_master: drives token streams into rpn_stack_master attached to a
// behavioural 10-entry LIFO and compares against a queue-based RPN evaluator.
module tb_rpn_stack_master;
  import rpn_pkg::*;

  localparam int W = 5;
  localparam int D = 10;

  logic clk = 1'b0;
  logic RstN = 1'b1;
  always #5 clk = ~clk;

  rpn_stack_master_if #(.WIDTH(W)) bus();

  logic [W-1:0] Result;
  logic         Result_Valid;
  logic         Err_Ovf;
  logic         Err_Unf;

  rpn_stack_master #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .RstN         (RstN),
    .bus          (bus),
    .Result       (Result),
    .Result_Valid (Result_Valid),
    .Err_Ovf      (Err_Ovf),
    .Err_Unf      (Err_Unf)
  );

  // Behavioural LIFO: output registered on the pop edge, reset with RstN.
  logic [W-1:0] stk_mem [D];
  int           stk_sp;

  always @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      stk_sp      <= 0;
      bus.St_Dout <= '0;
    end else begin
      if (bus.St_Push && stk_sp < D) begin
        stk_mem[stk_sp] <= bus.St_Din;
        stk_sp          <= stk_sp + 1;
      end else if (bus.St_Pop && stk_sp > 0) begin
        bus.St_Dout <= stk_mem[stk_sp-1];
        stk_sp      <= stk_sp - 1;
      end
    end
  end
  assign bus.St_Full     = (stk_sp == D);
  assign bus.St_Has_Data = (stk_sp != 0);

  int total = 0;
  int bad   = 0;
  int n_push = 0, n_pop = 0, n_rv = 0, n_hs = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Per-cycle strobe monitor.
  always @(negedge clk) begin
    if (RstN) begin
      chk("push_pop_excl", int'(bus.St_Push & bus.St_Pop), 0);
      if (bus.St_Push | bus.St_Pop) chk("ready_busy", int'(bus.Tok_Ready), 0);
      if (bus.St_Push) n_push++;
      if (bus.St_Pop) n_pop++;
      if (Result_Valid) n_rv++;
      if (bus.Tok_Valid & bus.Tok_Ready) n_hs++;
    end
  end

  // Reference evaluator.
  int m_q[$];
  int m_result = 0;
  int m_ovf = 0;
  int m_unf = 0;

  task automatic model_reset();
    m_q.delete();
    m_result = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input int typ, input int data,
                            output int ep, output int eo, output int er);
    int a, b, r;
    ep = 0; eo = 0; er = 0;
    case (typ)
      0: begin
        if (m_q.size() == D) m_ovf = 1;
        else begin m_q.push_back(data); ep = 1; end
      end
      1: begin
        if (m_q.size() < 2) m_unf = 1;
        else begin
          b = m_q.pop_back();
          a = m_q.pop_back();
          case (data % 4)
            0: r = (a + b) % 32;
            1: r = (a - b + 32) % 32;
            2: r = a & b;
            default: r = a ^ b;
          endcase
          m_q.push_back(r);
          eo = 2; ep = 1;
        end
      end
      2: begin
        if (m_q.size() == 0) m_unf = 1;
        else begin m_result = m_q.pop_back(); eo = 1; er = 1; end
      end
      default: ;
    endcase
  endtask

  task automatic wait_ready(input string name);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.Tok_Ready) break;
    end
    chk(name, int'(bus.Tok_Ready), 1);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send_token(input int typ, input int data);
    bus.Tok_Valid = 1'b1;
    bus.Tok_Type  = 2'(typ);
    bus.Tok_Data  = W'(data);
    wait_ready("ready_wait");
    @(posedge clk); #1;
    bus.Tok_Valid = 1'b0;
  endtask

  task automatic do_token(input int typ, input int data);
    int p0, o0, r0, h0, ep, eo, er;
    p0 = n_push; o0 = n_pop; r0 = n_rv; h0 = n_hs;
    model_step(typ, data, ep, eo, er);
    send_token(typ, data);
    wait_ready("idle_wait");
    @(posedge clk); #1;
    chk("push_count", n_push - p0, ep);
    chk("pop_count", n_pop - o0, eo);
    chk("rv_count", n_rv - r0, er);
    chk("hs_count", n_hs - h0, 1);
    chk("result", int'(Result), m_result);
    chk("err_ovf", int'(Err_Ovf), m_ovf);
    chk("err_unf", int'(Err_Unf), m_unf);
    chk("stack_depth", stk_sp, m_q.size());
  endtask

  typedef struct {
    int typ;
    int data;
    int exp_result;
    int exp_ovf;
    int exp_unf;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int t, int d, int r, int o, int u);
    vec_t v;
    v.typ = t; v.data = d; v.exp_result = r; v.exp_ovf = o; v.exp_unf = u;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int p0, o0, r0, h0, ep, eo, er, sp, so, sr, typ, data;

    tv.push_back(mk(0, 7, 0, 0, 0));
    tv.push_back(mk(0, 3, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 0));
    tv.push_back(mk(2, 0, 4, 0, 0));
    tv.push_back(mk(0, 30, 4, 0, 0));
    tv.push_back(mk(0, 5, 4, 0, 0));
    tv.push_back(mk(1, 0, 4, 0, 0));
    tv.push_back(mk(2, 0, 3, 0, 0));
    tv.push_back(mk(0, 2, 3, 0, 0));
    tv.push_back(mk(0, 5, 3, 0, 0));
    tv.push_back(mk(1, 1, 3, 0, 0));
    tv.push_back(mk(2, 0, 29, 0, 0));
    tv.push_back(mk(0, 12, 29, 0, 0));
    tv.push_back(mk(0, 10, 29, 0, 0));
    tv.push_back(mk(1, 2, 29, 0, 0));
    tv.push_back(mk(2, 0, 8, 0, 0));
    tv.push_back(mk(0, 12, 8, 0, 0));
    tv.push_back(mk(0, 10, 8, 0, 0));
    tv.push_back(mk(1, 3, 8, 0, 0));
    tv.push_back(mk(2, 0, 6, 0, 0));
    tv.push_back(mk(3, 5, 6, 0, 0));
    tv.push_back(mk(0, 4, 6, 0, 0));
    tv.push_back(mk(1, 0, 6, 0, 1));
    tv.push_back(mk(2, 0, 4, 0, 1));

    bus.Tok_Valid = 1'b0;
    bus.Tok_Type  = 2'b00;
    bus.Tok_Data  = '0;
    model_reset();
    #2 RstN = 1'b0;
    #1;
    chk("rst_ready", int'(bus.Tok_Ready), 0);
    chk("rst_push", int'(bus.St_Push), 0);
    chk("rst_pop", int'(bus.St_Pop), 0);
    chk("rst_din", int'(bus.St_Din), 0);
    chk("rst_result", int'(Result), 0);
    chk("rst_rv", int'(Result_Valid), 0);
    chk("rst_ovf", int'(Err_Ovf), 0);
    chk("rst_unf", int'(Err_Unf), 0);
    repeat (3) @(posedge clk);
    #1 RstN = 1'b1;

    // Scripted vectors: subtraction order, wrap, and/xor, reserved, underflow.
    for (int i = 0; i < tv.size(); i++) begin
      do_token(tv[i].typ, tv[i].data);
      chk("tbl_result", int'(Result), tv[i].exp_result);
      chk("tbl_ovf", int'(Err_Ovf), tv[i].exp_ovf);
      chk("tbl_unf", int'(Err_Unf), tv[i].exp_unf);
    end
    chk("tbl_end_depth", stk_sp, 0);

    // Reset while the operator sits in CAP_B.
    do_token(0, 1);
    do_token(0, 2);
    bus.Tok_Valid = 1'b1;
    bus.Tok_Type  = 2'(1);
    bus.Tok_Data  = '0;
    wait_ready("ready_wait");
    @(posedge clk); #1;
    bus.Tok_Valid = 1'b0;
    chk("popb_strobe", int'(bus.St_Pop), 1);
    @(posedge clk); #1;
    chk("capb_quiet", int'(bus.St_Pop | bus.St_Push), 0);
    RstN = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ready", int'(bus.Tok_Ready), 0);
    chk("mid_rst_push", int'(bus.St_Push), 0);
    chk("mid_rst_pop", int'(bus.St_Pop), 0);
    chk("mid_rst_result", int'(Result), 0);
    chk("mid_rst_unf", int'(Err_Unf), 0);
    repeat (2) @(posedge clk);
    #1 RstN = 1'b1;
    do_token(0, 1);
    do_token(2, 0);
    chk("after_rst_result", int'(Result), 1);

    // Overflow: ten operands fit, the eleventh is dropped.
    p0 = n_push;
    for (int i = 0; i < 11; i++) do_token(0, (i == 10) ? 31 : i + 1);
    chk("ovf_push_total", n_push - p0, 10);
    chk("ovf_flag", int'(Err_Ovf), 1);
    do_token(2, 0);
    chk("ovf_eval_result", int'(Result), 10);

    // Randomized tokens.
    for (int i = 0; i < 200; i++) begin
      typ = $urandom_range(0, 9);
      if (typ < 5) typ = 0;
      else if (typ < 8) typ = 1;
      else if (typ == 8) typ = 2;
      else typ = 3;
      do_token(typ, $urandom_range(0, 31));
    end

    // Back-to-back: Tok_Valid held high across all tokens.
    p0 = n_push; o0 = n_pop; r0 = n_rv; h0 = n_hs;
    sp = 0; so = 0; sr = 0;
    bus.Tok_Valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      typ  = (i % 4 == 3) ? 1 : ((i % 6 == 5) ? 2 : 0);
      data = $urandom_range(0, 31);
      model_step(typ, data, ep, eo, er);
      sp += ep; so += eo; sr += er;
      bus.Tok_Type = 2'(typ);
      bus.Tok_Data = W'(data);
      wait_ready("stream_ready");
      @(posedge clk); #1;
    end
    bus.Tok_Valid = 1'b0;
    wait_ready("stream_idle");
    @(posedge clk); #1;
    chk("stream_hs", n_hs - h0, 24);
    chk("stream_push", n_push - p0, sp);
    chk("stream_pop", n_pop - o0, so);
    chk("stream_rv", n_rv - r0, sr);
    chk("stream_result", int'(Result), m_result);
    chk("stream_depth", stk_sp, m_q.size());
    chk("stream_ovf", int'(Err_Ovf), m_ovf);
    chk("stream_unf", int'(Err_Unf), m_unf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
